// File: rtl/mlp_layer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mlp_pkg
//  Description : Shared types and helpers for the MLP layer sequencer.
//                - state_e : sequencer FSM state encoding
//                - addr_w  : neuron-index width (never below 1 bit)
//                - requant : round / shift / saturate / ReLU on a widened
//                            accumulator
//  Revision    : 1.0  initial release
// ============================================================================
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Working width for requantisation. The accumulator is sign-extended to
  // this width, so every layer width up to REQ_W-2 bits is handled without
  // overflow in the rounding add.
  localparam int REQ_W = 64;
  localparam logic signed [REQ_W-1:0] REQ_ONE = 1;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // acc   : the DATA_W-wrapped accumulator, sign-extended to REQ_W
  // data_w: width of the saturated result
  // frac_w: fraction bits to drop (round-half-up, then arithmetic shift)
  // relu  : clamp negative results to zero
  function automatic logic signed [REQ_W-1:0] requant(
    input logic signed [REQ_W-1:0] acc,
    input int                      data_w,
    input int                      frac_w,
    input bit                      relu
  );
    logic signed [REQ_W-1:0] sum;
    logic signed [REQ_W-1:0] shr;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    logic signed [REQ_W-1:0] res;
    sum = acc;
    if (frac_w > 0) begin
      sum = acc + (REQ_ONE <<< (frac_w - 1));
    end
    shr = sum >>> frac_w;
    hi  = (REQ_ONE <<< (data_w - 1)) - REQ_ONE;
    lo  = -(REQ_ONE <<< (data_w - 1));
    if (shr > hi) begin
      res = hi;
    end else if (shr < lo) begin
      res = lo;
    end else begin
      res = shr;
    end
    if (relu && (res < 0)) begin
      res = '0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_layer_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mlp_layer_seq_if
//  Description : Bundles the MLP layer sequencer's handshake, weight-memory
//                and dotprod connections.
//    in_valid/in_ready/in_vec      : input vector handshake
//    w_rd_en/w_addr/w_row/w_bias   : synchronous weight memory (1-cycle read)
//    dp_vec_a/dp_vec_b/dp_out      : external combinational dotprod
//    out_valid/out_ready/out_vec   : output vector handshake
//    busy                          : sequencer not idle
//  Modports    : slave  - the layer sequencer
//                master - the surrounding system (source, memory, dotprod,
//                         sink)
//  Revision    : 1.0  initial release
// ============================================================================
interface mlp_layer_seq_if
  import mlp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 4
);

  localparam int ADDR_W = addr_w(OUT_DIM);

  logic                           in_valid;
  logic                           in_ready;
  logic [IN_DIM-1:0][DATA_W-1:0]  in_vec;

  logic                           w_rd_en;
  logic [ADDR_W-1:0]              w_addr;
  logic [IN_DIM-1:0][DATA_W-1:0]  w_row;
  logic [DATA_W-1:0]              w_bias;

  logic [IN_DIM-1:0][DATA_W-1:0]  dp_vec_a;
  logic [IN_DIM-1:0][DATA_W-1:0]  dp_vec_b;
  logic [DATA_W-1:0]              dp_out;

  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_DIM-1:0][DATA_W-1:0] out_vec;

  logic                           busy;

  modport slave (
    input  in_valid, in_vec, w_row, w_bias, dp_out, out_ready,
    output in_ready, w_rd_en, w_addr, dp_vec_a, dp_vec_b, out_valid, out_vec,
           busy
  );

  modport master (
    output in_valid, in_vec, w_row, w_bias, dp_out, out_ready,
    input  in_ready, w_rd_en, w_addr, dp_vec_a, dp_vec_b, out_valid, out_vec,
           busy
  );

endinterface
`default_nettype wire

// File: rtl/mlp_layer_seq_requant.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_requant
//  Description : Combinational per-neuron post-processing:
//                bias add (wrapping at DATA_W), round-half-up, arithmetic
//                shift by FRAC_W, saturation to DATA_W, optional ReLU.
//  Ports       : dp_out  in  DATA_W  dot-product result
//                bias    in  DATA_W  neuron bias
//                res     out DATA_W  requantised neuron output
//  Revision    : 1.0  initial release
// ============================================================================
module mlp_requant
  import mlp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter int RELU   = 1
) (
  input  logic [DATA_W-1:0] dp_out,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0]       acc;
  logic signed [REQ_W-1:0] acc_ext;
  logic signed [REQ_W-1:0] full;
  logic                    unused_hi;

  // The bias add wraps exactly like the dotprod accumulator does; only
  // after wrapping is the value widened for the rounding step.
  assign acc     = dp_out + bias;
  assign acc_ext = {{(REQ_W - DATA_W){acc[DATA_W-1]}}, acc};
  assign full    = requant(acc_ext, DATA_W, FRAC_W, (RELU != 0));

  // Saturation guarantees the upper bits are pure sign copies.
  assign res       = full[DATA_W-1:0];
  assign unused_hi = ^full[REQ_W-1:DATA_W];

endmodule
`default_nettype wire

// File: rtl/mlp_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_layer_seq
//  Description : Sequences one fully-connected MLP layer around an external
//                combinational dotprod block. Captures an input vector,
//                then for each neuron reads a weight row + bias from a
//                synchronous memory (FETCH), lets dotprod combine it with
//                the stored input and requantises the result (CALC). The
//                finished vector is offered with a valid/ready handshake.
//  Ports       : clk     in  clock, rising edge
//                rst_n   in  asynchronous active-low reset
//                bus     mlp_layer_seq_if.slave (handshakes, weight memory,
//                        dotprod, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 4,
  parameter int FRAC_W  = 8,
  parameter int RELU    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mlp_layer_seq_if.slave bus
);

  localparam int                ADDR_W = addr_w(OUT_DIM);
  localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(OUT_DIM - 1);

  state_e                         state;
  state_e                         state_nxt;
  logic [ADDR_W-1:0]              n;
  logic [IN_DIM-1:0][DATA_W-1:0]  in_reg;
  logic [OUT_DIM-1:0][DATA_W-1:0] out_reg;
  logic [DATA_W-1:0]              neuron_res;
  logic                           accept;
  logic                           last_n;

  logic                           in_ready;
  logic                           w_rd_en;
  logic                           out_valid;
  logic                           busy;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last_n = (n == LAST_N);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = FETCH;
      FETCH:                      state_nxt = CALC;
      CALC:    if (last_n)        state_nxt = DONE;
               else               state_nxt = FETCH;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (all decoded from the registered state, so out_valid
  // cannot glitch, including across an asynchronous reset)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    w_rd_en   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      FETCH:   w_rd_en   = 1'b1;
      CALC:    ;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: input vector, neuron counter, output vector
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       <= '0;
      in_reg  <= '0;
      out_reg <= '0;
    end else begin
      if (accept) begin
        in_reg <= bus.in_vec;
        n      <= '0;
      end
      if (state == CALC) begin
        for (int k = 0; k < OUT_DIM; k++) begin
          if (n == ADDR_W'(k)) begin
            out_reg[k] <= neuron_res;
          end
        end
        // Counter parks on the last neuron; the next accept clears it.
        if (!last_n) begin
          n <= n + 1'b1;
        end
      end
    end
  end

  mlp_requant #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .RELU   (RELU)
  ) u_requant (
    .dp_out (bus.dp_out),
    .bias   (bus.w_bias),
    .res    (neuron_res)
  );

  assign bus.in_ready  = in_ready;
  assign bus.w_rd_en   = w_rd_en;
  assign bus.w_addr    = n;
  assign bus.dp_vec_a  = in_reg;
  assign bus.dp_vec_b  = bus.w_row;
  assign bus.out_valid = out_valid;
  assign bus.out_vec   = out_reg;
  assign bus.busy      = busy;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_layer_seq
//  Description : Self-checking bench for mlp_layer_seq. Models the weight
//                memory and the dotprod block, applies directed vectors and
//                compares against hand-computed results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mlp_layer_seq;
  import mlp_pkg::*;

  localparam int DW = 32;
  localparam int ID = 4;
  localparam int OD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_layer_seq_if #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD)) bus ();

  mlp_layer_seq #(
    .DATA_W (DW), .IN_DIM (ID), .OUT_DIM (OD), .FRAC_W (8), .RELU (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-alone requant instances for the corner-case parameter sets.
  logic [31:0] rq_dp, rq_bias, rq_f8, rq_f0, rq_relu;
  mlp_requant #(.DATA_W(32), .FRAC_W(8), .RELU(0)) rq_a (.dp_out(rq_dp), .bias(rq_bias), .res(rq_f8));
  mlp_requant #(.DATA_W(32), .FRAC_W(0), .RELU(0)) rq_b (.dp_out(rq_dp), .bias(rq_bias), .res(rq_f0));
  mlp_requant #(.DATA_W(32), .FRAC_W(8), .RELU(1)) rq_c (.dp_out(rq_dp), .bias(rq_bias), .res(rq_relu));

  // Weight memory model: synchronous read, data one cycle after w_rd_en.
  logic [3:0][31:0] wmem [4];
  logic [31:0]      bmem [4];
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_row  <= wmem[bus.w_addr];
      bus.w_bias <= bmem[bus.w_addr];
    end
  end

  // Dotprod model: wrapping sum of element products.
  always_comb begin : dotprod_model
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < ID; i++) begin
      s = s + bus.dp_vec_a[i] * bus.dp_vec_b[i];
    end
    bus.dp_out = s;
  end

  typedef struct {
    logic [31:0] dp;
    logic [31:0] bias;
    logic [31:0] e_f8;
    logic [31:0] e_f0;
    logic [31:0] e_relu;
  } rq_vec_t;

  typedef struct {
    logic [3:0][31:0] vin;
    logic [3:0][31:0] vexp;
  } layer_t;

  rq_vec_t rq_tab [7];
  layer_t  lt     [3];

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0][31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [3:0][31:0] r;
    r[0] = 32'(a0);
    r[1] = 32'(a1);
    r[2] = 32'(a2);
    r[3] = 32'(a3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_seen", 128'(bus.out_valid), 128'(1));
  endtask

  // Offer vector idx, follow the FETCH/CALC walk, check latency and result.
  task automatic run_layer(input int idx);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
    bus.in_vec   = lt[idx].vin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("dp_vec_a_capture", 128'(bus.dp_vec_a), 128'(lt[idx].vin));
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      chk("busy_run", 128'(bus.busy), 128'(1));
      chk("w_rd_en_phase", 128'(bus.w_rd_en), 128'(cyc % 2));
      if (cyc % 2 == 1) chk("w_addr", 128'(bus.w_addr), 128'((cyc - 1) / 2));
      @(negedge clk);
      cyc++;
    end
    chk("latency", 128'(cyc), 128'(9));
    for (int i = 0; i < OD; i++) begin
      chk($sformatf("out_vec[%0d]", i), 128'(bus.out_vec[i]), 128'(lt[idx].vexp[i]));
    end
  endtask

  task automatic finish_layer();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", 128'(bus.out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Stimulus tables
    rq_tab[0] = '{32'h7FFFFF00, 32'h7FFFFF00, 32'hFFFFFFFE, 32'hFFFFFE00, 32'h0};
    rq_tab[1] = '{32'h80000000, 32'h0,        32'hFF800000, 32'h80000000, 32'h0};
    rq_tab[2] = '{32'h7FFFFFFF, 32'h0,        32'h00800000, 32'h7FFFFFFF, 32'h00800000};
    rq_tab[3] = '{32'd384,      32'hFFFFFFFF, 32'd1,        32'd383,      32'd1};
    rq_tab[4] = '{32'd128,      32'h0,        32'd1,        32'd128,      32'd1};
    rq_tab[5] = '{32'hFFFFFF7F, 32'h0,        32'hFFFFFFFF, 32'hFFFFFF7F, 32'h0};
    rq_tab[6] = '{32'hFFFFFF80, 32'h0,        32'h0,        32'hFFFFFF80, 32'h0};

    wmem[0] = pack4(256, 256, 256, 256);     bmem[0] = 32'd128;
    wmem[1] = pack4(-256, -256, -256, -256); bmem[1] = 32'd0;
    wmem[2] = pack4(1, 2, 3, 4);             bmem[2] = 32'd1000;
    wmem[3] = pack4(-256, 0, 0, 7);          bmem[3] = 32'd70000;

    lt[0] = '{pack4(256, 512, -256, 0),  pack4(513, 0, 6, 17)};
    lt[1] = '{pack4(1000, -1000, 50, 7), pack4(58, 0, 1, 0)};
    lt[2] = '{pack4(0, 0, 0, 0),         pack4(1, 0, 4, 273)};

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    rq_dp   = '0;
    rq_bias = '0;

    // 1: reset values
    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_w_rd_en",   128'(bus.w_rd_en),   128'(0));
    chk("rst_w_addr",    128'(bus.w_addr),    128'(0));
    chk("rst_busy",      128'(bus.busy),      128'(0));
    chk("rst_out_vec",   128'(bus.out_vec),   128'(0));
    chk("rst_dp_vec_a",  128'(bus.dp_vec_a),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rel_busy",     128'(bus.busy),     128'(0));

    // 3: requant arithmetic table
    for (int i = 0; i < 7; i++) begin
      rq_dp   = rq_tab[i].dp;
      rq_bias = rq_tab[i].bias;
      #1;
      chk($sformatf("rq_f8[%0d]", i),   128'(rq_f8),   128'(rq_tab[i].e_f8));
      chk($sformatf("rq_f0[%0d]", i),   128'(rq_f0),   128'(rq_tab[i].e_f0));
      chk($sformatf("rq_relu[%0d]", i), 128'(rq_relu), 128'(rq_tab[i].e_relu));
    end

    // 2: layer run
    run_layer(0);
    finish_layer();

    // 4: backpressure, in_valid offered during DONE must be ignored
    run_layer(1);
    for (int k = 0; k < 5; k++) begin
      bus.in_vec   = lt[2].vin;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_in_ready",  128'(bus.in_ready),  128'(0));
      chk("bp_out_vec",   128'(bus.out_vec),   128'(lt[1].vexp));
      chk("bp_dp_vec_a",  128'(bus.dp_vec_a),  128'(lt[1].vin));
    end
    bus.in_valid = 1'b0;
    finish_layer();

    // 5: reset during CALC of neuron 2
    @(negedge clk);
    bus.in_vec   = lt[2].vin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_calc_rd_en", 128'(bus.w_rd_en), 128'(0));
    chk("mid_calc_addr",  128'(bus.w_addr),  128'(2));
    chk("mid_calc_busy",  128'(bus.busy),    128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vec",   128'(bus.out_vec),   128'(0));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_busy",      128'(bus.busy),      128'(0));
    chk("mid_rst_w_addr",    128'(bus.w_addr),    128'(0));
    chk("mid_rst_dp_vec_a",  128'(bus.dp_vec_a),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(2);
    finish_layer();

    // 6: back-to-back with in_valid held high
    @(negedge clk);
    bus.in_vec   = lt[0].vin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_vec = lt[1].vin;
    wait_out();
    chk("b2b_first_vec", 128'(bus.out_vec),  128'(lt[0].vexp));
    chk("b2b_first_a",   128'(bus.dp_vec_a), 128'(lt[0].vin));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_idle_ready", 128'(bus.in_ready),  128'(1));
    chk("b2b_idle_valid", 128'(bus.out_valid), 128'(0));
    chk("b2b_idle_a",     128'(bus.dp_vec_a),  128'(lt[0].vin));
    @(negedge clk);
    chk("b2b_second_busy", 128'(bus.busy),     128'(1));
    chk("b2b_second_a",    128'(bus.dp_vec_a), 128'(lt[1].vin));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_out();
    chk("b2b_second_vec", 128'(bus.out_vec), 128'(lt[1].vexp));
    finish_layer();
    @(negedge clk);
    chk("b2b_no_third", 128'(bus.busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
